// File: rtl/dpr_clr.sv
`default_nettype none
// ============================================================================
// Module   : dpr_clr
// Purpose  : Single-clock dual-port RAM with a built-in clear sweep.
//            Port 1 reads (registered, with a valid flag) and port 2 writes.
//            After reset (when CLEAR=1) or on an i_clr request, every word is
//            overwritten with FILL. o_ready is low while that sweep runs.
// Ports    : i_clk    - clock, all state changes on the rising edge
//            i_rst_n  - asynchronous active-low reset
//            o_ready  - array usable (low during a sweep)
//            i_clr    - one-cycle sweep request (honoured only when ready)
//            i_a1     - port 1 read address
//            i_r1     - port 1 read enable
//            o_q1     - port 1 registered read data
//            o_v1     - o_q1 was loaded on the previous edge
//            i_a2     - port 2 write address
//            i_d2     - port 2 write data
//            i_w2     - port 2 write enable
// Revision : 1.0 - initial release
// ============================================================================
module dpr_clr #(
   parameter int          AW    = 10,
   parameter int          DW    = 8,
   parameter int          MODE  = 0,
   parameter logic [DW-1:0] FILL = '1,
   parameter int          CLEAR = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   output logic          o_ready,
   input  logic          i_clr,
   input  logic [AW-1:0] i_a1,
   input  logic          i_r1,
   output logic [DW-1:0] o_q1,
   output logic          o_v1,
   input  logic [AW-1:0] i_a2,
   input  logic [DW-1:0] i_d2,
   input  logic          i_w2
);

   typedef enum logic [0:0] {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam logic [AW-1:0] c_LAST = '1;

   logic [DW-1:0] r_mem [2**AW];
   state_t        r_state;
   logic [AW-1:0] r_cnt;
   logic          r_ready;
   logic [DW-1:0] r_q1;
   logic          r_v1;

   logic          w_sweep;
   logic          w_we;
   logic [AW-1:0] w_wa;
   logic [DW-1:0] w_wd;
   logic [DW-1:0] w_rd;

   assign w_sweep = (r_state == ST_SWEEP);

   // The sweep owns the write port; port 2 is locked out until it finishes.
   // Writes are also suppressed while reset is held so the array is untouched.
   assign w_we = i_rst_n & (w_sweep | i_w2);
   assign w_wa = w_sweep ? r_cnt : i_a2;
   assign w_wd = w_sweep ? FILL  : i_d2;

   // Write-through mode forwards the incoming data on a same-address hit;
   // read-first mode simply sees the array before this edge's write.
   assign w_rd = ((MODE == 1) && i_w2 && (i_a1 == i_a2)) ? i_d2 : r_mem[i_a1];

   always_ff @(posedge i_clk) begin
      if (w_we) begin
         r_mem[w_wa] <= w_wd;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= (CLEAR != 0) ? ST_SWEEP : ST_RUN;
         r_cnt   <= '0;
         r_q1    <= '0;
         r_v1    <= 1'b0;
         r_ready <= (CLEAR == 0);
      end else begin
         case (r_state)
            ST_SWEEP: begin
               r_v1 <= 1'b0;
               // Terminal compare keeps the last address from wrapping back
               // into another pass.
               if (r_cnt == c_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            default: begin
               r_v1 <= i_r1;
               if (i_r1) begin
                  r_q1 <= w_rd;
               end
               // A read or write in the request cycle still completes above.
               if (i_clr) begin
                  r_state <= ST_SWEEP;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_ready = r_ready;
   assign o_q1    = r_q1;
   assign o_v1    = r_v1;

endmodule
`default_nettype wire

// File: tb/tb_dpr_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpr_clr
// Purpose  : Self-checking bench for dpr_clr. Three instances (AW=4, DW=8)
//            share all inputs: read-first/clear, write-through/clear and
//            read-first/no-clear. A behavioural model per instance predicts
//            o_ready/o_v1/o_q1 and is compared on every falling edge; a few
//            literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpr_clr;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int N  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic [AW-1:0] a1 = '0;
   logic          r1 = 1'b0;
   logic [AW-1:0] a2 = '0;
   logic [DW-1:0] d2 = '0;
   logic          w2 = 1'b0;

   logic          rdy [3];
   logic [DW-1:0] q   [3];
   logic          v   [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dpr_clr #(.AW(AW), .DW(DW), .MODE(0), .FILL(8'hFF), .CLEAR(1)) u_rf (
      .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[0]), .i_clr(clr),
      .i_a1(a1), .i_r1(r1), .o_q1(q[0]), .o_v1(v[0]),
      .i_a2(a2), .i_d2(d2), .i_w2(w2));

   dpr_clr #(.AW(AW), .DW(DW), .MODE(1), .FILL(8'hFF), .CLEAR(1)) u_wt (
      .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[1]), .i_clr(clr),
      .i_a1(a1), .i_r1(r1), .o_q1(q[1]), .o_v1(v[1]),
      .i_a2(a2), .i_d2(d2), .i_w2(w2));

   dpr_clr #(.AW(AW), .DW(DW), .MODE(0), .FILL(8'hFF), .CLEAR(0)) u_nc (
      .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy[2]), .i_clr(clr),
      .i_a1(a1), .i_r1(r1), .o_q1(q[2]), .o_v1(v[2]),
      .i_a2(a2), .i_d2(d2), .i_w2(w2));

   // ---------------- behavioural model ----------------
   // left[i] = sweep edges still to come (0 means usable).
   int          m_mode  [3] = '{0, 1, 0};
   int          m_clear [3] = '{1, 1, 0};
   logic [DW-1:0] mm    [3][N];
   bit          mk      [3][N];
   int          left    [3];
   logic [DW-1:0] mq    [3];
   bit          mqk     [3];
   bit          mv      [3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < N; k++) begin
            mm[i][k] = '0;
            mk[i][k] = 1'b0;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            left[i] = (m_clear[i] != 0) ? N : 0;
            mq[i]   = '0;
            mqk[i]  = 1'b1;
            mv[i]   = 1'b0;
         end else if (left[i] > 0) begin
            mm[i][N - left[i]] = 8'hFF;
            mk[i][N - left[i]] = 1'b1;
            left[i] = left[i] - 1;
            mv[i]   = 1'b0;
         end else begin
            mv[i] = r1;
            if (r1) begin
               if (m_mode[i] == 1 && w2 && a1 == a2) begin
                  mq[i]  = d2;
                  mqk[i] = 1'b1;
               end else begin
                  mq[i]  = mm[i][a1];
                  mqk[i] = mk[i][a1];
               end
            end
            if (w2) begin
               mm[i][a2] = d2;
               mk[i][a2] = 1'b1;
            end
            if (clr) left[i] = N;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rdy[i] !== (left[i] == 0)) begin
            errors++;
            $display("FAIL ready[%0d] t=%0t got %b exp %b", i, $time, rdy[i], (left[i] == 0));
         end
         checks++;
         if (v[i] !== mv[i]) begin
            errors++;
            $display("FAIL v1[%0d] t=%0t got %b exp %b", i, $time, v[i], mv[i]);
         end
         if (mqk[i]) begin
            checks++;
            if (q[i] !== mq[i]) begin
               errors++;
               $display("FAIL q1[%0d] t=%0t got %h exp %h", i, $time, q[i], mq[i]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic idle();
      r1 = 1'b0; w2 = 1'b0; clr = 1'b0;
   endtask

   initial begin
      idle();
      #22 rst_n = 1'b1;               // release between edges

      // reset sweep: 16 edges
      repeat (N - 1) tick();
      lit("reset_sweep_rdy_low_e15", {7'd0, rdy[0]}, 8'h00);
      lit("noclear_rdy_high", {7'd0, rdy[2]}, 8'h01);
      tick();
      lit("reset_sweep_rdy_high_e16", {7'd0, rdy[0]}, 8'h01);

      // read every address after the sweep
      for (int k = 0; k < N; k++) begin
         a1 = AW'(k); r1 = 1'b1;
         tick();
      end
      lit("fill_read_q", q[0], 8'hFF);
      lit("fill_read_v", {7'd0, v[0]}, 8'h01);

      // write then read
      idle(); a2 = 4'd3; d2 = 8'h5A; w2 = 1'b1;
      tick();
      idle(); a1 = 4'd3; r1 = 1'b1;
      tick();
      lit("wr_rd_q", q[0], 8'h5A);
      lit("wr_rd_v", {7'd0, v[0]}, 8'h01);
      idle();
      tick();
      lit("hold_v", {7'd0, v[0]}, 8'h00);
      lit("hold_q", q[0], 8'h5A);

      // collision at address 7
      a2 = 4'd7; d2 = 8'h11; w2 = 1'b1;
      tick();
      a2 = 4'd7; d2 = 8'h22; w2 = 1'b1; a1 = 4'd7; r1 = 1'b1;
      tick();
      lit("coll_mode0", q[0], 8'h11);
      lit("coll_mode1", q[1], 8'h22);
      w2 = 1'b0;
      tick();
      lit("coll_after_mode0", q[0], 8'h22);
      lit("coll_after_mode1", q[1], 8'h22);

      // no-clear instance: write/read address 0
      idle(); a2 = 4'd0; d2 = 8'hA5; w2 = 1'b1;
      tick();
      idle(); a1 = 4'd0; r1 = 1'b1;
      tick();
      lit("noclear_a5", q[2], 8'hA5);

      // clr together with a write and a read
      idle(); clr = 1'b1; a2 = 4'd2; d2 = 8'h33; w2 = 1'b1; a1 = 4'd3; r1 = 1'b1;
      tick();
      lit("clr_rdy_low", {7'd0, rdy[0]}, 8'h00);
      lit("clr_v_high", {7'd0, v[0]}, 8'h01);
      for (int k = 0; k < N - 1; k++) begin
         clr = 1'b1;                   // ignored during the sweep
         a1 = AW'($urandom_range(0, N - 1)); r1 = 1'($urandom_range(0, 1));
         a2 = AW'($urandom_range(0, N - 1)); d2 = 8'($urandom); w2 = 1'($urandom_range(0, 1));
         tick();
      end
      lit("clr_rdy_low_e15", {7'd0, rdy[0]}, 8'h00);
      idle();
      tick();
      lit("clr_rdy_high_e16", {7'd0, rdy[0]}, 8'h01);
      a1 = 4'd2; r1 = 1'b1;
      tick();
      lit("clr_addr2_ff", q[0], 8'hFF);

      // reset in the middle of a sweep
      idle(); clr = 1'b1;
      tick();
      idle();
      repeat (9) tick();
      #2 rst_n = 1'b0;
      #1;
      lit("midrst_q", q[0], 8'h00);
      lit("midrst_v", {7'd0, v[0]}, 8'h00);
      lit("midrst_rdy", {7'd0, rdy[0]}, 8'h00);
      lit("midrst_noclear_rdy", {7'd0, rdy[2]}, 8'h01);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (N - 1) tick();
      lit("midrst_rdy_low_e15", {7'd0, rdy[0]}, 8'h00);
      tick();
      lit("midrst_rdy_high_e16", {7'd0, rdy[0]}, 8'h01);
      a1 = 4'd9; r1 = 1'b1;
      tick();
      idle();
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
